// File: rtl/seg_scan_ctrl.sv
// Two-digit multiplexed display scanner: drives a shared 7-seg decoder and
// active-low anodes, with frame-synchronous digit commit and inter-digit dead time.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  input  logic       blank_lead,
  output logic [3:0] num,
  output logic [1:0] an,
  output logic       frame_start,
  output logic       pending
);

  localparam int MAXV = (REFRESH_DIV > DEAD_CYCLES) ?
                        ((REFRESH_DIV > 2) ? REFRESH_DIV : 2) :
                        ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
  localparam int TW = $clog2(MAXV);
  localparam logic [TW-1:0] SHOW_LAST = TW'(REFRESH_DIV - 1);
  // With zero dead time DEAD_0 still occurs once after reset, lasting one cycle.
  localparam logic [TW-1:0] DEAD_LAST = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {DEAD_0, SHOW_ONES, DEAD_1, SHOW_TENS} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic [3:0]    pend_ones_q, pend_ones_d, pend_tens_q, pend_tens_d;
  logic          pending_q, pending_d;
  logic [3:0]    num_q, num_d;
  logic [1:0]    an_q, an_d;
  logic          fs_q, fs_d;
  logic          commit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DEAD_0:    if (timer_q == DEAD_LAST) state_d = SHOW_ONES;
      SHOW_ONES: if (timer_q == SHOW_LAST) state_d = (DEAD_CYCLES == 0) ? SHOW_TENS : DEAD_1;
      DEAD_1:    if (timer_q == DEAD_LAST) state_d = SHOW_TENS;
      default:   if (timer_q == SHOW_LAST) state_d = (DEAD_CYCLES == 0) ? SHOW_ONES : DEAD_0;
    endcase
    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    commit  = (state_q == SHOW_TENS) && (state_d != SHOW_TENS);

    ones_d      = ones_q;
    tens_d      = tens_q;
    pend_ones_d = pend_ones_q;
    pend_tens_d = pend_tens_q;
    pending_d   = pending_q;
    if (commit) begin
      // A load on the commit edge bypasses the pending buffer.
      if (load) begin
        ones_d = ones_in;
        tens_d = tens_in;
      end else if (pending_q) begin
        ones_d = pend_ones_q;
        tens_d = pend_tens_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_ones_d = ones_in;
      pend_tens_d = tens_in;
      pending_d   = 1'b1;
    end

    an_d  = 2'b11;
    num_d = tens_d;
    case (state_d)
      DEAD_0:    num_d = ones_d;
      SHOW_ONES: begin
        an_d  = 2'b10;
        num_d = ones_d;
      end
      SHOW_TENS: an_d = (blank_lead && (tens_d == 4'd0)) ? 2'b11 : 2'b01;
      default:   an_d = 2'b11;
    endcase
    fs_d = (state_d == SHOW_ONES) && (state_q != SHOW_ONES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DEAD_0;
      timer_q     <= '0;
      ones_q      <= '0;
      tens_q      <= '0;
      pend_ones_q <= '0;
      pend_tens_q <= '0;
      pending_q   <= 1'b0;
      num_q       <= '0;
      an_q        <= 2'b11;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      pend_ones_q <= pend_ones_d;
      pend_tens_q <= pend_tens_d;
      pending_q   <= pending_d;
      num_q       <= num_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

  assign num         = num_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Two-digit display scan controller for the TwoDigitCounter design. It time-multiplexes one shared SevenSeg decoder between the ones and tens digits. It drives the decoder's 4-bit `num` input and the active-low digit anodes. Digit updates are double-buffered so the display changes only at frame boundaries, and a programmable dead time between digits suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 50000: cycles each digit is lit; legal range ≥1.
- `DEAD_CYCLES`, default 2: blanking cycles between digit slots; legal range ≥0.
- `clk`  in  1: single system clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `load`  in  1: capture `tens_in`/`ones_in` this cycle.
- `tens_in`  in  4: tens digit value.
- `ones_in`  in  4: ones digit value.
- `blank_lead`  in  1: suppress the tens digit when the committed tens value is 0.
- `num`  out  4: digit value to SevenSeg `num`; registered.
- `an`  out  2: anode enables, active-low; `an[0]`=ones, `an[1]`=tens; registered.
- `frame_start`  out  1: one-cycle pulse on the first SHOW_ONES cycle of each frame.
- `pending`  out  1: a loaded value is waiting for commit.

## Operation
- Four states, cycling in this order: DEAD_0 → SHOW_ONES → DEAD_1 → SHOW_TENS → DEAD_0.
- SHOW states last exactly `REFRESH_DIV` cycles. DEAD states last exactly `DEAD_CYCLES` cycles.
- If `DEAD_CYCLES`=0, DEAD_1 is skipped and DEAD_0 is skipped, except as the reset state.
- Frame period is 2·(`REFRESH_DIV`+`DEAD_CYCLES`) cycles.
- Outputs per state:
  - DEAD_0: `an`=11, `num`=committed ones (pre-settles the decoder).
  - SHOW_ONES: `an`=10, `num`=committed ones.
  - DEAD_1: `an`=11, `num`=committed tens.
  - SHOW_TENS: `an`=01, `num`=committed tens. If `blank_lead`=1 and committed tens=0, `an`=11 instead; `blank_lead` is sampled every cycle.
- Double buffering:
  - `load`=1 writes `tens_in`/`ones_in` into the pending register and sets `pending`.
  - A newer `load` overwrites an uncommitted one.
  - Commit copies pending to committed on the edge leaving SHOW_TENS, and only if `pending`=1. `pending` clears on that edge.
  - If `load` coincides with the commit edge, the values presented that cycle are committed directly and `pending` stays 0.
- Committed values never change at any other time.
- Digit values 10–15 pass through unchanged; decoding them is SevenSeg's responsibility.
- `timer` width is the `$clog2` of max(`REFRESH_DIV`,`DEAD_CYCLES`,2). It counts 0..N-1 within a state and resets to 0 on every state change.

## Timing
- Reset (edge sampling `rst_n`=0):
  - state=DEAD_0, timer=0.
  - `an`=11, `num`=0, `frame_start`=0, `pending`=0.
  - Committed and pending registers=0.
  - `load` is ignored while `rst_n`=0.
- After reset release, DEAD_0 lasts max(`DEAD_CYCLES`,1) cycles, then SHOW_ONES begins with `frame_start`=1 for that cycle.
- Reset mid-frame aborts the frame on the same edge; no commit occurs.
- Latency from `load` to visible digit:
  - Worst case is one frame period plus the time remaining in SHOW_TENS.
  - New values appear first in the DEAD_0 and SHOW_ONES cycles following the commit edge.
- All outputs are registered. `an` and `num` change only on state transitions, or on a `blank_lead` change during SHOW_TENS.
- `an` is never 00.

## Test plan
- **Reset and free-run**, `REFRESH_DIV`=4, `DEAD_CYCLES`=1:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
  - Required: `an` sequence per cycle 11,10,10,10,10,11,01,01,01,01, repeating with period 10.
  - Required: `frame_start` high on cycle 2 and every 10 cycles after; `num`=0 throughout.
- **Double buffering**:
  - Stimulus: `load` tens=4, ones=7 during SHOW_ONES.
  - Required: `pending`=1 and display still shows 0/0 until SHOW_TENS ends.
  - Required: next frame `num`=7 with `an`=10, then `num`=4 with `an`=01; `pending` returns to 0.
- **Overwrite and coincident load**:
  - Stimulus: load 1/2, then 3/5 before commit.
  - Required: 3/5 is committed, never 1/2.
  - Stimulus: `load` 9/9 exactly on the last SHOW_TENS cycle.
  - Required: 9/9 appears next frame with `pending` never asserted.
- **Leading-zero blanking**:
  - Stimulus: committed 0/6 with `blank_lead`=1.
  - Required: `an`=11 during SHOW_TENS, SHOW_ONES normal.
  - Stimulus: toggle `blank_lead` to 0 mid-slot.
  - Required: `an`=01 from the next cycle.
- **`DEAD_CYCLES`=0**, `REFRESH_DIV`=3:
  - Required: period 6 with `an` 10,10,10,01,01,01.
  - Required: `an` never 11 after the first post-reset cycle.
- **Reset mid-operation**:
  - Stimulus: assert `rst_n`=0 for one cycle during SHOW_TENS with `pending`=1.
  - Required: next cycle `an`=11, `num`=0, `pending`=0; the pending value is discarded.
